// File: rtl/tile_map_arbiter.sv
// tile_map_arbiter: shares the tile-map BRAM between the video renderer and game-logic commands, plus a clear-map fill
module tile_map_arbiter #(
  parameter int MAP_W = 20,
  parameter int MAP_H = 15,
  parameter logic [3:0] CLEAR_VALUE = 4'h1,
  parameter logic [3:0] OOR_CELL = 4'hF
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Vid_Req,
  input  logic [4:0] i_Vid_X,
  input  logic [3:0] i_Vid_Y,
  output logic       o_Vid_Valid,
  output logic [3:0] o_Vid_Cell,
  input  logic       i_Cmd_Valid,
  output logic       o_Cmd_Ready,
  input  logic       i_Cmd_Write,
  input  logic [4:0] i_Cmd_X,
  input  logic [3:0] i_Cmd_Y,
  input  logic [3:0] i_Cmd_Data,
  output logic       o_Rsp_Valid,
  output logic [3:0] o_Rsp_Data,
  output logic       o_Rsp_Err,
  input  logic       i_Clear_Start,
  output logic       o_Clear_Busy,
  output logic       o_Clear_Done,
  output logic [8:0] o_Ram_RAddr,
  input  logic [7:0] i_Ram_RData,
  output logic [8:0] o_Ram_WAddr,
  output logic [7:0] o_Ram_WData,
  output logic       o_Ram_WE
);
  localparam int MAP_BYTES = MAP_W * MAP_H / 2;
  localparam logic [8:0] LAST = 9'(MAP_BYTES - 1);
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WRITE, RESP, CLEAR} state_t;
  state_t state, state_nxt;
  logic [8:0] cnt, cmd_addr;
  logic [7:0] byte_q;
  logic [3:0] cmd_data, rsp_data;
  logic cmd_write, cmd_hi, cmd_err, accept, acc_oor, vid_oor, vid_v1, vid_hi1, vid_oor1;
  function automatic logic [8:0] cell_addr(input logic [4:0] x, input logic [3:0] y);
    return 9'(y) * 9'(MAP_W / 2) + 9'(x[4:1]);
  endfunction
  assign acc_oor = int'(i_Cmd_X) >= MAP_W || int'(i_Cmd_Y) >= MAP_H;
  assign vid_oor = int'(i_Vid_X) >= MAP_W || int'(i_Vid_Y) >= MAP_H;
  assign o_Cmd_Ready = state == IDLE && !i_Reset;
  assign accept = o_Cmd_Ready && i_Cmd_Valid && !i_Clear_Start;
  assign o_Clear_Busy = state == CLEAR;
  assign o_Rsp_Valid = state == RESP;
  assign o_Rsp_Data = state == RESP ? rsp_data : 4'h0;
  assign o_Rsp_Err = state == RESP && cmd_err;
  assign o_Ram_RAddr = i_Vid_Req ? cell_addr(i_Vid_X, i_Vid_Y) : state == RD_ISSUE ? cmd_addr : 9'd0;
  assign o_Ram_WE = state == WRITE || state == CLEAR;
  assign o_Ram_WAddr = state == CLEAR ? cnt : state == WRITE ? cmd_addr : 9'd0;
  assign o_Ram_WData = state == CLEAR ? {CLEAR_VALUE, CLEAR_VALUE} :
                       state == WRITE ? (cmd_hi ? {cmd_data, byte_q[3:0]} : {byte_q[7:4], cmd_data}) : 8'h00;
  // state register
  always_ff @(posedge i_Clk)
    state <= i_Reset ? IDLE : state_nxt;
  // next-state: video owns the read port, so a pending command read waits in RD_ISSUE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = i_Clear_Start ? CLEAR : accept ? (acc_oor ? RESP : RD_ISSUE) : IDLE;
      RD_ISSUE: state_nxt = i_Vid_Req ? RD_ISSUE : RD_WAIT;
      RD_WAIT:  state_nxt = cmd_write ? WRITE : RESP;
      WRITE:    state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      CLEAR:    state_nxt = cnt == LAST ? IDLE : CLEAR;
      default:  state_nxt = IDLE;
    endcase
  end
  // command latch, read-modify-write byte capture, response data and fill counter
  always_ff @(posedge i_Clk)
    if (i_Reset) begin
      cmd_write <= 1'b0;
      cmd_hi <= 1'b0;
      cmd_addr <= 9'd0;
      cmd_data <= 4'h0;
      cmd_err <= 1'b0;
      byte_q <= 8'h00;
      rsp_data <= 4'h0;
      cnt <= 9'd0;
      o_Clear_Done <= 1'b0;
    end else begin
      if (accept) begin
        cmd_write <= i_Cmd_Write;
        cmd_hi <= i_Cmd_X[0];
        cmd_addr <= cell_addr(i_Cmd_X, i_Cmd_Y);
        cmd_data <= i_Cmd_Data;
        cmd_err <= acc_oor;
        rsp_data <= 4'h0;
      end
      if (state == RD_WAIT) begin
        byte_q <= i_Ram_RData;
        rsp_data <= cmd_hi ? i_Ram_RData[7:4] : i_Ram_RData[3:0];
      end
      if (state == WRITE) rsp_data <= cmd_data;
      cnt <= state == CLEAR && cnt != LAST ? cnt + 9'd1 : 9'd0;
      o_Clear_Done <= state == CLEAR && cnt == LAST;
    end
  // two-stage video pipe: nibble select and range flag meet the BRAM data one cycle later
  always_ff @(posedge i_Clk)
    if (i_Reset) begin
      vid_v1 <= 1'b0;
      vid_hi1 <= 1'b0;
      vid_oor1 <= 1'b0;
      o_Vid_Valid <= 1'b0;
      o_Vid_Cell <= 4'h0;
    end else begin
      vid_v1 <= i_Vid_Req;
      vid_hi1 <= i_Vid_X[0];
      vid_oor1 <= vid_oor;
      o_Vid_Valid <= vid_v1;
      if (vid_v1) o_Vid_Cell <= vid_oor1 ? OOR_CELL : vid_hi1 ? i_Ram_RData[7:4] : i_Ram_RData[3:0];
    end
endmodule

// File: tb/tb_tile_map_arbiter.sv
// tb_tile_map_arbiter: directed and random checks of the tile-map arbiter against a cell-level map model
module tb_tile_map_arbiter;
  localparam int MAP_W = 20;
  localparam int MAP_H = 15;
  localparam int MAP_BYTES = MAP_W * MAP_H / 2;
  localparam logic [3:0] CLEAR_VALUE = 4'h1;
  logic clk = 1'b0, rst = 1'b1;
  logic vid_req = 1'b0, cmd_valid = 1'b0, cmd_write = 1'b0, clear_start = 1'b0;
  logic [4:0] vid_x = '0, cmd_x = '0;
  logic [3:0] vid_y = '0, cmd_y = '0, cmd_data = '0;
  logic vid_valid, cmd_ready, rsp_valid, rsp_err, clear_busy, clear_done, we;
  logic [3:0] vid_cell, rsp_data;
  logic [8:0] raddr, waddr;
  logic [7:0] rdata, wdata;
  logic [7:0] bram [0:511];
  logic [3:0] ref_cells [0:MAP_W-1][0:MAP_H-1];
  int compared = 0, mismatched = 0;
  logic vid_en = 1'b0;
  logic p1v, p2v;
  logic [3:0] p1c, p2c, exp_cell;

  tile_map_arbiter dut (
    .i_Clk(clk), .i_Reset(rst),
    .i_Vid_Req(vid_req), .i_Vid_X(vid_x), .i_Vid_Y(vid_y),
    .o_Vid_Valid(vid_valid), .o_Vid_Cell(vid_cell),
    .i_Cmd_Valid(cmd_valid), .o_Cmd_Ready(cmd_ready), .i_Cmd_Write(cmd_write),
    .i_Cmd_X(cmd_x), .i_Cmd_Y(cmd_y), .i_Cmd_Data(cmd_data),
    .o_Rsp_Valid(rsp_valid), .o_Rsp_Data(rsp_data), .o_Rsp_Err(rsp_err),
    .i_Clear_Start(clear_start), .o_Clear_Busy(clear_busy), .o_Clear_Done(clear_done),
    .o_Ram_RAddr(raddr), .i_Ram_RData(rdata),
    .o_Ram_WAddr(waddr), .o_Ram_WData(wdata), .o_Ram_WE(we)
  );

  always #5 clk = ~clk;

  // BRAM stand-in: one-cycle read latency, read-before-write
  always @(posedge clk) begin
    if (we) bram[waddr] <= wdata;
    rdata <= bram[raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_vid(input int x, input int y);
    return (x >= MAP_W || y >= MAP_H) ? 4'hF : ref_cells[x][y];
  endfunction

  // video scoreboard: result due two cycles after each request, cell holds otherwise
  always @(negedge clk) begin
    #2;
    if (!vid_en) begin
      p1v = 0; p2v = 0; p1c = 0; p2c = 0; exp_cell = 0;
    end else begin
      check("vid_valid", vid_valid, p2v);
      if (p2v) exp_cell = p2c;
      check("vid_cell", vid_cell, exp_cell);
      p2v = p1v; p2c = p1c;
      p1v = vid_req;
      p1c = vid_req ? exp_vid(vid_x, vid_y) : 4'h0;
    end
  end

  task automatic do_cmd(input logic w, input int x, input int y, input logic [3:0] d, input int stall);
    bit oor, got;
    int addr, exp_lat, lat, we_n, rdy_bad;
    logic [7:0] exp_wd;
    logic [3:0] exp_rd, got_data;
    logic got_err;
    oor = x >= MAP_W || y >= MAP_H;
    addr = y * (MAP_W / 2) + x / 2;
    exp_lat = oor ? 1 : (w ? 4 : 3) + stall;
    exp_wd = 8'h00;
    if (!oor) exp_wd = (x % 2 == 1) ? {d, ref_cells[x-1][y]} : {ref_cells[x+1][y], d};
    exp_rd = oor ? 4'h0 : w ? d : ref_cells[x][y];
    got = 0; lat = 0; we_n = 0; rdy_bad = 0; got_data = 0; got_err = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = w; cmd_x = x[4:0]; cmd_y = y[3:0]; cmd_data = d;
    #1 check("cmd_ready", cmd_ready, 1);
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      cmd_valid = 0;
      vid_req = c <= stall;
      if (vid_req) begin
        vid_x = 5'($urandom_range(0, 31));
        vid_y = 4'($urandom_range(0, 15));
      end
      #1;
      if (c == 1 && !oor && stall == 0) check("cmd_raddr", raddr, addr);
      if (vid_req && vid_x < MAP_W && vid_y < MAP_H)
        check("stall_vid_raddr", raddr, int'(vid_y) * (MAP_W / 2) + int'(vid_x) / 2);
      if (cmd_ready) rdy_bad++;
      if (we) begin
        we_n++;
        check("we_cycle", c, exp_lat - 1);
        check("waddr", waddr, addr);
        check("wdata", wdata, exp_wd);
      end
      if (rsp_valid) begin
        got = 1; lat = c; got_data = rsp_data; got_err = rsp_err;
      end
    end
    vid_req = 0;
    check("rsp_latency", lat, exp_lat);
    check("rsp_data", got_data, exp_rd);
    check("rsp_err", got_err, oor);
    check("we_count", we_n, (w && !oor) ? 1 : 0);
    check("ready_busy", rdy_bad, 0);
    if (w && !oor) ref_cells[x][y] = d;
  endtask

  task automatic run_clear(input bit with_cmd);
    int k, busy_n, done_n, rdy_bad, rsp_n;
    k = 0; busy_n = 0; done_n = 0; rdy_bad = 0; rsp_n = 0;
    @(negedge clk);
    clear_start = 1;
    if (with_cmd) begin
      cmd_valid = 1; cmd_write = 0; cmd_x = 5'd5; cmd_y = 4'd7; cmd_data = 4'h9;
    end
    #1 check("clr_ready_idle", cmd_ready, 1);
    for (int c = 1; c <= 160; c++) begin
      @(negedge clk);
      clear_start = 0;
      if (c == 152) cmd_valid = 0;
      #1;
      if (we) begin
        check("clr_waddr", waddr, k);
        check("clr_wdata", wdata, {CLEAR_VALUE, CLEAR_VALUE});
        k++;
      end
      busy_n += int'(clear_busy);
      if (clear_busy && cmd_ready) rdy_bad++;
      if (clear_done) begin
        done_n++;
        check("clr_done_cycle", c, MAP_BYTES + 1);
        check("clr_ready_after", cmd_ready, 1);
      end
      if (rsp_valid) begin
        rsp_n++;
        check("clr_cmd_rsp_cycle", c, MAP_BYTES + 4);
        check("clr_cmd_rsp_data", rsp_data, CLEAR_VALUE);
      end
    end
    check("clr_we_count", k, MAP_BYTES);
    check("clr_busy_count", busy_n, MAP_BYTES);
    check("clr_done_count", done_n, 1);
    check("clr_ready_low", rdy_bad, 0);
    check("clr_rsp_count", rsp_n, with_cmd ? 1 : 0);
    for (int x = 0; x < MAP_W; x++)
      for (int y = 0; y < MAP_H; y++)
        ref_cells[x][y] = CLEAR_VALUE;
  endtask

  initial begin
    int rw_bad;
    for (int i = 0; i < 512; i++) bram[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_raddr", raddr, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_done", clear_done, 0);
    check("rst_vid_valid", vid_valid, 0);
    check("rst_vid_cell", vid_cell, 0);
    vid_en = 1;
    run_clear(0);
    do_cmd(1, 3, 2, 4'h2, 0);
    do_cmd(0, 2, 2, 4'h0, 0);
    do_cmd(0, 3, 2, 4'h0, 10);
    do_cmd(1, 20, 0, 4'h5, 0);
    do_cmd(0, 0, 15, 4'h0, 0);
    @(negedge clk);
    vid_req = 1; vid_x = 5'd3; vid_y = 4'd2;
    @(negedge clk);
    vid_x = 5'd25; vid_y = 4'd0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      vid_req = 1'($urandom_range(0, 1));
      vid_x = 5'($urandom_range(0, 31));
      vid_y = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    vid_req = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 40; i++)
      do_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 21), $urandom_range(0, 15),
             4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_x = 5'd7; cmd_y = 4'd4; cmd_data = ~ref_cells[7][4];
    #1 check("rwait_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    rst = 1; vid_en = 0;
    @(negedge clk);
    rst = 0;
    #1 check("rwait_ready_after", cmd_ready, 1);
    rw_bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (we || rsp_valid) rw_bad++;
    end
    check("rwait_no_we_rsp", rw_bad, 0);
    vid_en = 1;
    do_cmd(0, 7, 4, 4'h0, 0);
    run_clear(1);
    do_cmd(0, 11, 9, 4'h0, 0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
